// File: rtl/mem_byte_ctrl.sv
// Byte-serialising responder for the MEM stage data port: each 32-bit request
// becomes one 8-bit access per selected lane on a synchronous RAM port.
module mem_byte_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       mem_data_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]        state;
    logic              we_r;
    logic [ADDR_W-3:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rd_buf;
    logic [3:0]        mask;
    logic [3:0]        mask_nxt;
    logic [1:0]        lane_r;
    logic [1:0]        prev_lane;
    logic              prev_vld;
    logic [1:0]        first_lane;
    logic [1:0]        next_lane;
    logic              unused_addr;

    // Lane i is address offset i and data bits [31-8i:24-8i] (big-endian packing).
    function automatic logic [1:0] low_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] l);
        return d[{~l, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [1:0] l);
        return {24'd0, b} << {~l, 3'b000};
    endfunction

    assign unused_addr = ^{mem_addr_i[31:ADDR_W], mem_addr_i[1:0]};

    always_comb begin
        mask_nxt   = mask & ~(4'b0001 << lane_r);
        next_lane  = low_lane(mask_nxt);
        first_lane = low_lane(mem_sel_i);
    end

    always_comb begin
        stall_o = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:           stall_o = mem_ce_i;
                ACCESS, RDWAIT: stall_o = 1'b1;
                default:        stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            rd_buf     <= '0;
            mask       <= '0;
            lane_r     <= '0;
            prev_lane  <= '0;
            prev_vld   <= 1'b0;
            mem_data_o <= '0;
            ram_addr_o <= '0;
            ram_wr_o   <= 1'b0;
            ram_dout_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ram_wr_o <= 1'b0;
                    if (mem_ce_i) begin
                        we_r     <= mem_we_i;
                        addr_r   <= mem_addr_i[ADDR_W-1:2];
                        wdata_r  <= mem_data_i;
                        mask     <= mem_sel_i;
                        rd_buf   <= '0;
                        prev_vld <= 1'b0;
                        if (mem_sel_i != 4'b0000) begin
                            lane_r     <= first_lane;
                            ram_addr_o <= {mem_addr_i[ADDR_W-1:2], first_lane};
                            ram_dout_o <= lane_byte(mem_data_i, first_lane);
                            ram_wr_o   <= mem_we_i;
                            state      <= ACCESS;
                        end else begin
                            if (!mem_we_i)
                                mem_data_o <= '0;
                            state <= DONE;
                        end
                    end
                end

                ACCESS: begin
                    if (!mem_ce_i) begin
                        ram_wr_o <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        // Read data returned now belongs to the lane presented last cycle.
                        if (!we_r && prev_vld)
                            rd_buf <= rd_buf | place_byte(ram_din_i, prev_lane);
                        prev_lane <= lane_r;
                        prev_vld  <= 1'b1;
                        mask      <= mask_nxt;
                        if (mask_nxt != 4'b0000) begin
                            lane_r     <= next_lane;
                            ram_addr_o <= {addr_r, next_lane};
                            ram_dout_o <= lane_byte(wdata_r, next_lane);
                            ram_wr_o   <= we_r;
                        end else begin
                            ram_wr_o <= 1'b0;
                            state    <= we_r ? DONE : RDWAIT;
                        end
                    end
                end

                RDWAIT: begin
                    ram_wr_o <= 1'b0;
                    if (!mem_ce_i) begin
                        state <= IDLE;
                    end else begin
                        // Merge the final byte straight into the output so it is valid during DONE.
                        mem_data_o <= rd_buf | place_byte(ram_din_i, lane_r);
                        state      <= DONE;
                    end
                end

                default: begin
                    ram_wr_o <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Self-checking bench for mem_byte_ctrl: an 8-bit synchronous RAM plus a
// word-level reference memory predicting stalls, RAM writes and load data.
module tb_mem_byte_ctrl;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_ce_i;
    logic          mem_we_i;
    logic [31:0]   mem_addr_i;
    logic [3:0]    mem_sel_i;
    logic [31:0]   mem_data_i;
    logic [31:0]   mem_data_o;
    logic          stall_o;
    logic [AW-1:0] ram_addr_o;
    logic          ram_wr_o;
    logic [7:0]    ram_dout_o;
    logic [7:0]    ram_din_i;

    always #5 clk = ~clk;

    mem_byte_ctrl #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .stall_o    (stall_o),
        .ram_addr_o (ram_addr_o),
        .ram_wr_o   (ram_wr_o),
        .ram_dout_o (ram_dout_o),
        .ram_din_i  (ram_din_i)
    );

    logic [7:0]    ram     [0:(1<<AW)-1];
    logic [7:0]    ref_mem [0:(1<<AW)-1];
    logic          init_req;
    logic [AW+7:0] wlog[$];
    logic [AW+7:0] exp_w[$];
    logic [31:0]   last_rd;
    int            vectors = 0;
    int            miscompares = 0;

    function automatic logic [7:0] seed_byte(input int unsigned a);
        return 8'((a * 37) ^ (a >> 7) ^ 32'h5A);
    endfunction

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= seed_byte(i);
        end else begin
            if (ram_wr_o) begin
                ram[ram_addr_o] <= ram_dout_o;
                wlog.push_back({ram_addr_o, ram_dout_o});
            end
            ram_din_i <= ram[ram_addr_o];
        end
    end

    // Request-level model: byte lanes in ascending offset order, lane i = data[31-8i -: 8].
    task automatic model_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] data, output int est, output logic [31:0] erd);
        int k = $countones(sel);
        logic [AW-1:0] a;
        exp_w.delete();
        est = (sel == 4'b0000) ? 1 : k + (we ? 1 : 2);
        if (we) begin
            for (int i = 0; i < 4; i++) if (sel[i]) begin
                a = {addr[AW-1:2], 2'(i)};
                ref_mem[a] = data[31-8*i -: 8];
                exp_w.push_back({a, data[31-8*i -: 8]});
            end
            erd = last_rd;
        end else begin
            erd = '0;
            for (int i = 0; i < 4; i++) if (sel[i]) begin
                a = {addr[AW-1:2], 2'(i)};
                erd[31-8*i -: 8] = ref_mem[a];
            end
            last_rd = erd;
        end
    endtask

    task automatic run_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data, input bit b2b, input int abort_at,
                           output int stalls, output logic [31:0] rdata);
        wlog.delete();
        mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
        if (b2b) begin @(negedge clk); #1; end
        else #1;
        stalls = 0;
        while (stall_o === 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk);
            if (abort_at != 0 && stalls == abort_at) mem_ce_i = 1'b0;
            #1;
        end
        rdata = mem_data_o;
    endtask

    task automatic idle_cycle();
        mem_ce_i = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic check_writes(input string name);
        bit ok = (wlog.size() == exp_w.size());
        foreach (exp_w[j]) if (ok && wlog[j] !== exp_w[j]) ok = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s writes: got %0d entries (first %h), expected %0d entries (first %h)",
                     name, wlog.size(), (wlog.size() > 0) ? wlog[0] : '0,
                     exp_w.size(), (exp_w.size() > 0) ? exp_w[0] : '0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF;
        mem_addr_i = 32'h100; mem_data_i = 32'hDEADBEEF;
        @(negedge clk); #1;
        vectors++;
        if ({stall_o, ram_wr_o, ram_addr_o, ram_dout_o, mem_data_o} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got stall=%b wr=%b addr=%h dout=%h data=%h, expected all 0",
                     stall_o, ram_wr_o, ram_addr_o, ram_dout_o, mem_data_o);
        end
        mem_ce_i = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        last_rd = '0;
    endtask

    task automatic test_directed();
        logic        t_we   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_addr [6] = '{32'h100, 32'h100, 32'h102, 32'h100, 32'h102, 32'h104};
        logic [3:0]  t_sel  [6] = '{4'b1111, 4'b1111, 4'b0100, 4'b1111, 4'b1100, 4'b0000};
        logic [31:0] t_data [6] = '{32'h11223344, 32'h0, 32'hAAAAAAAA, 32'h0, 32'h0, 32'h0};
        int          t_st   [6] = '{5, 6, 2, 6, 4, 1};
        logic [31:0] t_rd   [6] = '{32'h0, 32'h11223344, 32'h11223344, 32'h1122AA44,
                                    32'h0000AA44, 32'h0};
        int est, stalls;
        logic [31:0] erd, rd;
        for (int n = 0; n < 6; n++) begin
            model_req(t_we[n], t_addr[n], t_sel[n], t_data[n], est, erd);
            run_req(t_we[n], t_addr[n], t_sel[n], t_data[n], 1'b0, 0, stalls, rd);
            vectors++;
            if (stalls !== t_st[n]) begin
                miscompares++;
                $display("FAIL directed%0d stall: got %0d cycles, expected %0d", n, stalls, t_st[n]);
            end
            vectors++;
            if (rd !== t_rd[n]) begin
                miscompares++;
                $display("FAIL directed%0d data: got %h, expected %h", n, rd, t_rd[n]);
            end
            check_writes($sformatf("directed%0d", n));
            idle_cycle();
        end
    endtask

    task automatic test_random(input int count, input bit b2b_mode);
        int est, stalls;
        logic [31:0] erd, rd, addr, data;
        logic [3:0] sel;
        logic we;
        for (int n = 0; n < count; n++) begin
            we = 1'($urandom_range(0, 1)); sel = 4'($urandom_range(0, 15));
            addr = $urandom; data = $urandom;
            model_req(we, addr, sel, data, est, erd);
            run_req(we, addr, sel, data, b2b_mode && (n > 0), 0, stalls, rd);
            vectors++;
            if (stalls !== est) begin
                miscompares++;
                $display("FAIL random%0d stall (we=%b sel=%b): got %0d, expected %0d",
                         n, we, sel, stalls, est);
            end
            vectors++;
            if (rd !== erd) begin
                miscompares++;
                $display("FAIL random%0d data (we=%b sel=%b addr=%h): got %h, expected %h",
                         n, we, sel, addr, rd, erd);
            end
            check_writes($sformatf("random%0d", n));
            if (!b2b_mode) idle_cycle();
        end
        if (b2b_mode) idle_cycle();
    endtask

    task automatic test_abort();
        int est, stalls, k, m, cnt;
        logic [31:0] erd, rd, addr, data;
        logic [3:0] sel;
        logic [AW-1:0] a;
        for (int n = 0; n < 8; n++) begin
            bit we = (n < 6);
            sel  = (n < 6) ? 4'($urandom_range(1, 15)) : 4'hF;
            addr = $urandom; data = $urandom;
            k = $countones(sel); m = $urandom_range(1, k);
            exp_w.delete(); cnt = 0;
            if (we) for (int i = 0; i < 4; i++) if (sel[i] && cnt < m) begin
                a = {addr[AW-1:2], 2'(i)};
                ref_mem[a] = data[31-8*i -: 8];
                exp_w.push_back({a, data[31-8*i -: 8]});
                cnt++;
            end
            run_req(we, addr, sel, data, 1'b0, m, stalls, rd);
            vectors++;
            if (stalls !== m + 1 || stall_o !== 1'b0) begin
                miscompares++;
                $display("FAIL abort%0d stall: got %0d cycles (stall now %b), expected %0d then 0",
                         n, stalls, stall_o, m + 1);
            end
            vectors++;
            if (rd !== last_rd) begin
                miscompares++;
                $display("FAIL abort%0d data: got %h, expected unchanged %h", n, rd, last_rd);
            end
            check_writes($sformatf("abort%0d", n));
            idle_cycle();
            model_req(1'b0, addr, 4'hF, 32'h0, est, erd);
            run_req(1'b0, addr, 4'hF, 32'h0, 1'b0, 0, stalls, rd);
            vectors++;
            if (rd !== erd) begin
                miscompares++;
                $display("FAIL abort%0d readback: got %h, expected %h", n, rd, erd);
            end
            idle_cycle();
        end
    endtask

    task automatic test_reset_mid_store();
        int est, stalls;
        logic [31:0] erd, rd;
        wlog.delete();
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h100; mem_sel_i = 4'hF;
        mem_data_i = 32'h11CCDDEE;
        @(negedge clk);
        @(negedge clk); #1;
        vectors++;
        if (ram_addr_o !== 17'h101 || ram_wr_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset presented: got addr=%h wr=%b, expected addr=00101 wr=1",
                     ram_addr_o, ram_wr_o);
        end
        rst = 1'b1; #1;
        vectors++;
        if ({ram_wr_o, stall_o, ram_addr_o, mem_data_o} !== '0) begin
            miscompares++;
            $display("FAIL midreset outputs: got wr=%b stall=%b addr=%h data=%h, expected all 0",
                     ram_wr_o, stall_o, ram_addr_o, mem_data_o);
        end
        mem_ce_i = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        ref_mem[17'h100] = 8'h11;
        last_rd = '0;
        exp_w.delete(); exp_w.push_back({17'h100, 8'h11});
        check_writes("midreset");
        idle_cycle();
        model_req(1'b0, 32'h100, 4'hF, 32'h0, est, erd);
        run_req(1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 0, stalls, rd);
        vectors++;
        if (rd !== erd) begin
            miscompares++;
            $display("FAIL midreset readback: got %h, expected %h", rd, erd);
        end
        idle_cycle();
    endtask

    initial begin
        init_req = 1'b1;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = seed_byte(i);
        @(posedge clk);
        @(negedge clk);
        init_req = 1'b0;
        test_reset();
        test_directed();
        test_random(40, 1'b0);
        test_random(12, 1'b1);
        test_abort();
        test_reset_mid_store();
        test_random(10, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_byte_ctrl.md
Name: mem_byte_ctrl

Overview:
- Responder for the MEM stage's data-memory request port: ce/we/addr/sel/data.
- Serialises each 32-bit request into byte accesses on an 8-bit synchronous RAM port.
- Returns assembled read data to the MEM stage as its mem_data_i.
- Holds the pipeline with stall_o until the request completes.

Parameters:
ADDR_W, 17, RAM byte-address width; ram_addr_o = {mem_addr_i[ADDR_W-1:2], lane[1:0]}

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
mem_ce_i  input  1  request valid, from MEM stage mem_ce_o
mem_we_i  input  1  1 = write, 0 = read
mem_addr_i  input  32  byte address; bits [1:0] ignored, lane taken from sel
mem_sel_i  input  4  lane enables; sel[i] = byte at address offset i = data bits [31-8i:24-8i]
mem_data_i  input  32  store data, lane-packed per sel mapping
mem_data_o  output  32  load data, same lane packing; to MEM stage mem_data_i
stall_o  output  1  pipeline stall request
ram_addr_o  output  ADDR_W  RAM byte address, registered
ram_wr_o  output  1  RAM write strobe, registered
ram_dout_o  output  8  RAM write byte, registered
ram_din_i  input  8  RAM read byte; valid the cycle after its address is presented

Behaviour:
- Reset (async, rst=1): state IDLE; stall_o=0; ram_wr_o=0; ram_addr_o=0; ram_dout_o=0; mem_data_o=0; lane mask=0.
- States: IDLE, ACCESS, RDWAIT, DONE.
- IDLE:
  - stall_o = mem_ce_i.
  - On a clock edge with mem_ce_i=1: latch we, addr and data; pending mask = mem_sel_i; clear read buffer.
  - If mask != 0: load first lane (lowest set bit) into ram_addr_o/ram_dout_o; ram_wr_o=we; go to ACCESS.
  - If mask == 0: go to DONE with no RAM access.
- ACCESS:
  - stall_o=1.
  - Each cycle presents one lane. On the edge: clear that lane's bit from the mask and load the next set lane in ascending order.
  - On reads, ram_din_i is captured into the previous presented lane's buffer byte.
  - After the last lane: writes go to DONE with ram_wr_o=0; reads go to RDWAIT.
- RDWAIT:
  - stall_o=1; ram_wr_o=0.
  - Capture the final byte into its lane, then go to DONE.
- DONE:
  - stall_o=0.
  - mem_data_o = read buffer; unselected lanes are 0. For writes mem_data_o is unchanged.
  - Next state is IDLE unconditionally. The requester advances its pipeline on this edge.
- mem_data_o is registered and holds its value outside DONE.
- Latency, k = number of set sel bits:
  - write: stall_o high k+1 cycles, then one DONE cycle.
  - read: stall_o high k+2 cycles, then DONE.
  - sel=0000: stall exactly 1 cycle.
- RAM writes occur on consecutive cycles, one byte each. Reads are pipelined: a new address every cycle, data one cycle later.
- Requester must hold ce/we/addr/sel/data stable while stall_o=1. The controller uses latched copies, so mid-request changes have no effect.
- Abort: if mem_ce_i=0 while in ACCESS or RDWAIT:
  - next edge goes to IDLE with ram_wr_o=0;
  - no further RAM cycles are issued;
  - mem_data_o is unchanged.
  Bytes already written stay written.
- Address: mem_addr_i[31:ADDR_W] is ignored; upper bits wrap.
- Reset mid-request: all outputs clear immediately, and the in-flight write strobe drops asynchronously. Partially written bytes remain in RAM.
- Back-to-back requests: a new ce=1 seen in IDLE right after DONE starts a new transaction. There are no idle gaps beyond the DONE→IDLE cycle.

Test Plan:
- Full-word store: ce=1 we=1 addr=0x100 sel=1111 data=0x11223344 -> RAM writes 0x100=11, 0x101=22, 0x102=33, 0x103=44 on 4 consecutive cycles; stall_o high 5 cycles, then low 1 cycle.
- Full-word load: ce=1 we=0 addr=0x100 sel=1111 -> ram_addr_o steps 0x100..0x103; stall_o high 6 cycles; mem_data_o=0x11223344 in DONE.
- Byte store then word load: SB addr=0x102 sel=0100 data=0xAAAAAAAA -> single write 0x102=AA, stall 2 cycles. Then LW 0x100 -> mem_data_o=0x1122AA44.
- Halfword load: addr=0x102 sel=1100 -> reads 0x102 and 0x103; mem_data_o=0x0000AA44; stall 4 cycles.
- Empty select: ce=1 sel=0000 -> stall_o high exactly 1 cycle, ram_wr_o never asserted, mem_data_o=0.
- Reset mid-store: rst pulsed while the 0x101 byte of a full-word store is presented -> ram_wr_o and stall_o drop immediately, no write to 0x102/0x103. A later load of 0x100 returns 0x11xxxxxx, where xx = prior contents of 0x101–0x103.
